branch_redirect_ctrl: RTL and testbench

//  EX-stage consumer of the Branch Unit. Turns branch/jump resolution into a registered PC redirect for fetch.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/branch_redirect_ctrl_if.sv | 32 +++
 rtl/pc_target_gen.sv | 24 ++
 rtl/branch_redirect_ctrl.sv | 70 +++++++
 tb/tb_branch_redirect_ctrl.sv | 132 +++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath width, branch funct3 codes and redirect FSM states.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;
endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// branch_redirect_ctrl_if: EX resolution inputs plus redirect/flush/trap outputs of the redirect controller.
interface branch_redirect_ctrl_if #(parameter int XLEN = riscv_pkg::XLEN);
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] Rs1;
    logic            Branch_taken;
    logic            ex_pred_taken;
    logic            br_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;
    modport master (
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_pc, ex_imm, Rs1,
               Branch_taken, ex_pred_taken, redirect_ready,
        input  br_en, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               misalign_exc, misalign_addr
    );
    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_pc, ex_imm, Rs1,
               Branch_taken, ex_pred_taken, redirect_ready,
        output br_en, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               misalign_exc, misalign_addr
    );
endinterface

// File: rtl/pc_target_gen.sv
// pc_target_gen: selects the next-PC target (JALR > JAL > branch > fall-through) and flags
// misalignment of any taken target.
module pc_target_gen import riscv_pkg::*; (
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            br_taken,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] target,
    output logic            misalign
);
    logic [XLEN-1:0] jalr_t;
    logic [XLEN-1:0] rel_t;
    logic [XLEN-1:0] ft_t;
    logic            taken;
    assign jalr_t = (rs1 + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign rel_t  = pc + imm;
    assign ft_t   = pc + XLEN'(4);
    assign taken  = is_jalr | is_jal | br_taken;
    assign target = is_jalr ? jalr_t : (is_jal | br_taken) ? rel_t : ft_t;
    // fall-through is sequential fetch, so it never raises a misalign trap
    assign misalign = taken & (target[1:0] != 2'b00);
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns EX branch/jump resolution into a registered fetch redirect with flushes.
// Optional BTFN_PREDICT_EN: branches redirect on prediction mismatch instead of on taken.
module branch_redirect_ctrl import riscv_pkg::*; (
    input  logic                   CLK,
    input  logic                   rst_n,
    branch_redirect_ctrl_if.slave  bus
);
    state_t          state;
    logic            need;
    logic            need_br;
    logic            br_taken;
    logic            misalign;
    logic [XLEN-1:0] target;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic            exc_q;
    logic [XLEN-1:0] addr_q;
    assign br_taken = bus.ex_is_branch & bus.Branch_taken;
`ifdef BTFN_PREDICT_EN
    assign need_br = bus.ex_is_branch & (bus.Branch_taken ^ bus.ex_pred_taken);
`else
    logic unused_pred;
    assign unused_pred = bus.ex_pred_taken;
    assign need_br     = br_taken;
`endif
    assign need = bus.ex_valid & (bus.ex_is_jalr | bus.ex_is_jal | need_br);
    pc_target_gen u_tgt (
        .is_jal   (bus.ex_is_jal),
        .is_jalr  (bus.ex_is_jalr),
        .br_taken (br_taken),
        .pc       (bus.ex_pc),
        .imm      (bus.ex_imm),
        .rs1      (bus.Rs1),
        .target   (target),
        .misalign (misalign)
    );
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            exc_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            exc_q <= 1'b0;
            if (state == REDIRECT) begin
                if (bus.redirect_ready) begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            end else if (need) begin
                if (misalign) begin
                    exc_q  <= 1'b1;
                    addr_q <= target;
                end else begin
                    state   <= REDIRECT;
                    valid_q <= 1'b1;
                    pc_q    <= target;
                end
            end
        end
    end
    assign bus.br_en          = bus.ex_valid & bus.ex_is_branch & (state == IDLE);
    assign bus.redirect_valid = valid_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.flush_if_id    = valid_q;
    assign bus.flush_id_ex    = valid_q;
    assign bus.misalign_exc   = exc_q;
    assign bus.misalign_addr  = addr_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_branch_redirect_ctrl;
    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    always #5 CLK = ~CLK;
`ifdef BTFN_PREDICT_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif
    branch_redirect_ctrl_if bus();
    branch_redirect_ctrl dut (.CLK(CLK), .rst_n(rst_n), .bus(bus.slave));
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic        m_exc = 1'b0;
    logic [31:0] m_addr = '0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic check_outs();
        chk("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, m_valid});
        chk("flush_if_id", {31'b0, bus.flush_if_id}, {31'b0, m_valid});
        chk("flush_id_ex", {31'b0, bus.flush_id_ex}, {31'b0, m_valid});
        chk("redirect_pc", bus.redirect_pc, m_pc);
        chk("misalign_exc", {31'b0, bus.misalign_exc}, {31'b0, m_exc});
        chk("misalign_addr", bus.misalign_addr, m_addr);
    endtask
    // one clock of traffic: drive at negedge, model the edge, compare at the following negedge
    task automatic cycle(input logic v, br, jal, jalr, input logic [31:0] pc, imm, rs1,
                         input logic tk, pr, rdy);
        logic [31:0] t;
        logic        taken, nd;
        bus.ex_valid = v; bus.ex_is_branch = br; bus.ex_is_jal = jal; bus.ex_is_jalr = jalr;
        bus.ex_pc = pc; bus.ex_imm = imm; bus.Rs1 = rs1;
        bus.Branch_taken = tk; bus.ex_pred_taken = pr; bus.redirect_ready = rdy;
        #1 chk("br_en", {31'b0, bus.br_en}, {31'b0, v & br & ~m_valid});
        @(posedge CLK);
        if (m_valid) begin
            m_exc = 1'b0;
            if (rdy) m_valid = 1'b0;
        end else begin
            m_exc = 1'b0;
            if (jalr) t = (rs1 + imm) / 2 * 2;
            else if (jal) t = pc + imm;
            else t = (br && tk) ? pc + imm : pc + 4;
            taken = jalr || jal || (br && tk);
            nd = jalr || jal || (br && (BTFN ? (tk != pr) : tk));
            if (v && nd) begin
                if (taken && (t % 4 != 0)) begin
                    m_exc = 1'b1;
                    m_addr = t;
                end else begin
                    m_valid = 1'b1;
                    m_pc = t;
                end
            end
        end
        @(negedge CLK);
        check_outs();
    endtask
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, bus.redirect_valid}, 32'd0);
        chk("rst_flush_if_id", {31'b0, bus.flush_if_id}, 32'd0);
        chk("rst_flush_id_ex", {31'b0, bus.flush_id_ex}, 32'd0);
        chk("rst_exc", {31'b0, bus.misalign_exc}, 32'd0);
        m_valid = 1'b0; m_pc = '0; m_exc = 1'b0; m_addr = '0;
        @(negedge CLK);
        rst_n = 1'b1;
        check_outs();
    endtask
    initial begin
        logic [31:0] imm;
        logic [2:0]  kind;
        bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_is_jal = 0; bus.ex_is_jalr = 0;
        bus.ex_pc = 0; bus.ex_imm = 0; bus.Rs1 = 0;
        bus.Branch_taken = 0; bus.ex_pred_taken = 0; bus.redirect_ready = 0;
        @(negedge CLK);
        check_outs();
        chk("reset_pc", bus.redirect_pc, 32'h0);
        rst_n = 1'b1;
        cycle(1, 1, 0, 0, 32'h100, 32'h20, 0, 1, 1, 0);
        chk("t1_valid", {31'b0, bus.redirect_valid}, 32'd1);
        chk("t1_pc", bus.redirect_pc, 32'h120);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 32'h300, 32'h40, 0, 1, 1, 0);
            chk("t4_hold_pc", bus.redirect_pc, 32'h120);
            chk("t4_hold_flush", {31'b0, bus.flush_id_ex}, 32'd1);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_idle", {31'b0, bus.redirect_valid}, 32'd0);
        cycle(1, 1, 0, 0, 32'h100, 32'h8, 0, 0, 0, 1);
        chk("t2_no_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        cycle(1, 0, 0, 1, 0, 32'h3, 32'h2001, 0, 0, 1);
        chk("t3_jalr_pc", bus.redirect_pc, 32'h2004);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 1, 0, 32'h10, 32'h6, 0, 0, 0, 1);
        chk("t3_exc", {31'b0, bus.misalign_exc}, 32'd1);
        chk("t3_addr", bus.misalign_addr, 32'h16);
        chk("t3_no_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t3_exc_drop", {31'b0, bus.misalign_exc}, 32'd0);
        cycle(1, 1, 0, 0, 32'h100, 32'h20, 0, 1, 1, 0);
        async_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef BTFN_PREDICT_EN
        cycle(1, 1, 0, 0, 32'h200, 32'hFFFF_FFC0, 0, 0, 1, 0);
        chk("t6_ft_pc", bus.redirect_pc, 32'h204);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 32'h200, 32'hFFFF_FFC0, 0, 1, 1, 1);
        chk("t6_no_redirect", {31'b0, bus.redirect_valid}, 32'd0);
`endif
        for (int i = 0; i < 1500; i++) begin
            kind = 3'($urandom_range(0, 7));
            imm = $urandom();
            if (!kind[2]) imm[0] = 1'b0;
            if ($urandom_range(0, 99) == 0) async_reset();
            else cycle($urandom_range(0, 9) < 7, kind[0], kind[1], kind[2],
                       $urandom() & 32'hFFFF_FFFC, imm, $urandom(),
                       1'($urandom()), 1'($urandom()), 1'($urandom()));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
